// File: rtl/pqp_multiciclo.sv
// pqp_multiciclo: multi-cycle PQP core with one shared memory port.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, plus absorbing HALT.
// Every memory access is a held request that completes on i_MemReady.
module pqp_multiciclo #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              NUM_REGS = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    output logic              o_MemReq,
    output logic              o_MemWe,
    output logic [ADDR_W-1:0] o_MemAddr,
    output logic [DATA_W-1:0] o_MemWData,
    input  logic [DATA_W-1:0] i_MemRData,
    input  logic              i_MemReady,
    output logic [ADDR_W-1:0] o_Pc,
    output logic              o_Halted,
    output logic              o_Illegal
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_ADDI = 8'h05;
    localparam logic [7:0] OP_LW   = 8'h06;
    localparam logic [7:0] OP_SW   = 8'h07;
    localparam logic [7:0] OP_BEQ  = 8'h08;
    localparam logic [7:0] OP_JMP  = 8'h09;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, mdr_q;
    logic [DATA_W-1:0] rf [NUM_REGS];
    logic              req_q, we_q, halted_q, illegal_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [7:0]        opcode;
    logic [3:0]        ra, rb;
    logic [DATA_W-1:0] imm_d;
    logic [ADDR_W-1:0] imm_a;
    logic [ADDR_W-1:0] pc_inc, br_tgt;
    logic [DATA_W-1:0] ra_val, rb_val, alu_res, wb_val;

    assign opcode = ir_q[31:24];
    assign ra     = ir_q[23:20];
    assign rb     = ir_q[19:16];
    assign imm_d  = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign imm_a  = {{(ADDR_W-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_inc = pc_q + ADDR_W'(4);
    // pc_q already holds PC+4 once the fetch has been accepted
    assign br_tgt = pc_q + (imm_a << 2);
    assign wb_val = (opcode == OP_LW) ? mdr_q : res_q;

    // Request is a pure state register, but is squashed while reset is high
    // so nothing can complete on the reset edge.
    assign o_MemReq   = req_q & ~i_Rst;
    assign o_MemWe    = we_q;
    assign o_MemAddr  = addr_q;
    assign o_MemWData = wdata_q;
    assign o_Pc       = pc_q;
    assign o_Halted   = halted_q;
    assign o_Illegal  = illegal_q;

    // Register file read: r0 and out-of-range indices read as zero
    always_comb begin
        ra_val = '0;
        rb_val = '0;
        if (ra != 4'd0 && 32'(ra) < NUM_REGS) ra_val = rf[ra];
        if (rb != 4'd0 && 32'(rb) < NUM_REGS) rb_val = rf[rb];
    end

    // ALU result, also used as the LW/SW effective address
    always_comb begin
        alu_res = a_q;
        case (opcode)
            OP_ADD:       alu_res = a_q + b_q;
            OP_SUB:       alu_res = a_q - b_q;
            OP_AND:       alu_res = a_q & b_q;
            OP_OR:        alu_res = a_q | b_q;
            OP_ADDI:      alu_res = a_q + imm_d;
            OP_LW, OP_SW: alu_res = b_q + imm_d;
            default:      ;
        endcase
    end

    // Control FSM, datapath registers and registered memory-port outputs
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            mdr_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
            req_q     <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= RESET_PC;
            wdata_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (i_MemReady) begin
                        ir_q  <= i_MemRData[31:0];
                        pc_q  <= pc_inc;
                        req_q <= 1'b0;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= ra_val;
                    b_q <= rb_val;
                    case (opcode)
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            state    <= S_HALT;
                        end
                        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                        OP_LW, OP_SW, OP_BEQ, OP_JMP:
                            state <= S_EXEC;
                        default: begin
                            halted_q  <= 1'b1;
                            illegal_q <= 1'b1;
                            state     <= S_HALT;
                        end
                    endcase
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                            state <= S_WB;
                        OP_LW, OP_SW: begin
                            req_q   <= 1'b1;
                            we_q    <= (opcode == OP_SW);
                            addr_q  <= alu_res[ADDR_W-1:0];
                            wdata_q <= a_q;
                            state   <= S_MEM;
                        end
                        OP_JMP: begin
                            pc_q   <= br_tgt;
                            req_q  <= 1'b1;
                            addr_q <= br_tgt;
                            state  <= S_FETCH;
                        end
                        OP_BEQ: begin
                            if (a_q == b_q) begin
                                pc_q   <= br_tgt;
                                addr_q <= br_tgt;
                            end else begin
                                addr_q <= pc_q;
                            end
                            req_q <= 1'b1;
                            state <= S_FETCH;
                        end
                        default: begin
                            req_q  <= 1'b1;
                            addr_q <= pc_q;
                            state  <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (i_MemReady) begin
                        if (we_q) begin
                            we_q   <= 1'b0;
                            addr_q <= pc_q;
                            state  <= S_FETCH;
                        end else begin
                            req_q <= 1'b0;
                            mdr_q <= i_MemRData;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (ra != 4'd0 && 32'(ra) < NUM_REGS) rf[ra] <= wb_val;
                    req_q  <= 1'b1;
                    addr_q <= pc_q;
                    state  <= S_FETCH;
                end
                default: ; // S_HALT: frozen until reset
            endcase
        end
    end

endmodule

// File: tb/tb_pqp_multiciclo.sv
// Directed bench for pqp_multiciclo with a 1 KB word memory model.
module tb_pqp_multiciclo;

    logic        i_Clk, i_Rst;
    logic        o_MemReq, o_MemWe;
    logic [31:0] o_MemAddr, o_MemWData, i_MemRData;
    logic        i_MemReady;
    logic [31:0] o_Pc;
    logic        o_Halted, o_Illegal;

    logic [31:0] mem [256];
    logic        rdy;
    int          wr_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          n, w0;

    pqp_multiciclo dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .o_MemReq   (o_MemReq),
        .o_MemWe    (o_MemWe),
        .o_MemAddr  (o_MemAddr),
        .o_MemWData (o_MemWData),
        .i_MemRData (i_MemRData),
        .i_MemReady (i_MemReady),
        .o_Pc       (o_Pc),
        .o_Halted   (o_Halted),
        .o_Illegal  (o_Illegal)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    assign i_MemReady = rdy;
    assign i_MemRData = mem[o_MemAddr[9:2]];

    // memory write port, completes only on an accepted write request
    always @(posedge i_Clk) begin
        if (o_MemReq && o_MemWe && i_MemReady) begin
            mem[o_MemAddr[9:2]] <= o_MemWData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] w);
        mem[a[9:2]] <= w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        rdy   = 1'b1;
        step();
        i_Rst = 1'b0;
        #1;
    endtask

    task automatic run_until_halt(input int max, output int cyc);
        cyc = 0;
        while (!o_Halted && cyc < max) begin
            step();
            cyc++;
        end
    endtask

    function automatic logic [33:0] port();
        return {o_MemReq, o_MemWe, o_MemAddr};
    endfunction

    initial begin
        i_Rst = 1'b1;
        rdy   = 1'b1;

        // ---------------- A: ALU program, reset state, halt timing
        clear_mem();
        load(32'h00, enc(8'h05, 4'd1, 4'd0, 16'd5));
        load(32'h04, enc(8'h05, 4'd2, 4'd0, 16'd7));
        load(32'h08, enc(8'h01, 4'd1, 4'd2, 16'd0));
        load(32'h0C, enc(8'hFF, 4'd0, 4'd0, 16'd0));
        step();
        step();
        chk("rst_req",     64'(o_MemReq),  64'd0);
        chk("rst_pc",      64'(o_Pc),      64'h0);
        chk("rst_halted",  64'(o_Halted),  64'd0);
        chk("rst_illegal", 64'(o_Illegal), 64'd0);
        i_Rst = 1'b0;
        #1;
        chk("first_fetch", 64'(port()), {30'd0, 1'b1, 1'b0, 32'h0});
        repeat (13) step();
        chk("A_halt_c13", 64'(o_Halted), 64'd0);
        step();
        chk("A_halt_c14", 64'(o_Halted),  64'd1);
        chk("A_pc",       64'(o_Pc),      64'h10);
        chk("A_illegal",  64'(o_Illegal), 64'd0);
        chk("A_req_off",  64'(o_MemReq),  64'd0);

        // ---------------- B: ALU/ADDI/LW/SW results through memory
        clear_mem();
        load(32'h00, enc(8'h05, 4'd1, 4'd0, 16'd5));
        load(32'h04, enc(8'h05, 4'd2, 4'd0, 16'd7));
        load(32'h08, enc(8'h01, 4'd1, 4'd2, 16'd0));
        load(32'h0C, enc(8'h07, 4'd1, 4'd0, 16'h280));
        load(32'h10, enc(8'h06, 4'd4, 4'd0, 16'h300));
        load(32'h14, enc(8'h07, 4'd4, 4'd0, 16'h240));
        load(32'h18, enc(8'h06, 4'd3, 4'd0, 16'h240));
        load(32'h1C, enc(8'h07, 4'd3, 4'd0, 16'h244));
        load(32'h20, enc(8'h02, 4'd2, 4'd1, 16'd0));
        load(32'h24, enc(8'h07, 4'd2, 4'd0, 16'h284));
        load(32'h28, enc(8'h03, 4'd4, 4'd2, 16'd0));
        load(32'h2C, enc(8'h07, 4'd4, 4'd0, 16'h288));
        load(32'h30, enc(8'h04, 4'd1, 4'd4, 16'd0));
        load(32'h34, enc(8'h07, 4'd1, 4'd0, 16'h28C));
        load(32'h38, enc(8'h05, 4'd0, 4'd0, 16'd9));
        load(32'h3C, enc(8'h07, 4'd0, 4'd0, 16'h290));
        load(32'h40, enc(8'hFF, 4'd0, 4'd0, 16'd0));
        load(32'h300, 32'hDEADBEEF);
        load(32'h290, 32'h55555555);
        do_reset();
        w0 = wr_cnt;
        run_until_halt(200, n);
        chk("B_cycles",  64'(n),             64'd68);
        chk("B_pc",      64'(o_Pc),          64'h44);
        chk("B_add",     64'(mem[8'hA0]),    64'h0000000C);
        chk("B_sw_lw",   64'(mem[8'h90]),    64'hDEADBEEF);
        chk("B_lw_sw",   64'(mem[8'h91]),    64'hDEADBEEF);
        chk("B_sub",     64'(mem[8'hA1]),    64'hFFFFFFFB);
        chk("B_and",     64'(mem[8'hA2]),    64'hDEADBEEB);
        chk("B_or",      64'(mem[8'hA3]),    64'hDEADBEEF);
        chk("B_r0_zero", 64'(mem[8'hA4]),    64'h0);
        chk("B_wr_cnt",  64'(wr_cnt - w0),   64'd7);

        // ---------------- C: SW request shape, wait states on FETCH and LW MEM
        clear_mem();
        load(32'h00, enc(8'h06, 4'd4, 4'd0, 16'h100));
        load(32'h04, enc(8'h07, 4'd4, 4'd0, 16'h40));
        load(32'h08, enc(8'h06, 4'd3, 4'd0, 16'h40));
        load(32'h0C, enc(8'h07, 4'd3, 4'd0, 16'h44));
        load(32'h10, enc(8'hFF, 4'd0, 4'd0, 16'd0));
        load(32'h100, 32'hDEADBEEF);
        do_reset();
        repeat (5) step();
        chk("C_lw_5cyc", 64'(port()), {30'd0, 1'b1, 1'b0, 32'h4});
        repeat (3) step();
        chk("C_sw_req",   64'(port()),     {30'd0, 1'b1, 1'b1, 32'h40});
        chk("C_sw_wdata", 64'(o_MemWData), 64'hDEADBEEF);
        step();
        chk("C_fetch8", 64'(port()), {30'd0, 1'b1, 1'b0, 32'h8});
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("C_fetch_stall", 64'(port()), {30'd0, 1'b1, 1'b0, 32'h8});
        end
        rdy = 1'b1;
        step();
        step();
        step();
        chk("C_lw_req", 64'(port()), {30'd0, 1'b1, 1'b0, 32'h40});
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("C_mem_stall", 64'(port()), {30'd0, 1'b1, 1'b0, 32'h40});
        end
        rdy = 1'b1;
        step();
        chk("C_wb_noreq", 64'(o_MemReq), 64'd0);
        step();
        chk("C_lw_11cyc", 64'(port()), {30'd0, 1'b1, 1'b0, 32'hC});
        run_until_halt(50, n);
        chk("C_tail",   64'(n),         64'd6);
        chk("C_mem40",  64'(mem[8'h10]), 64'hDEADBEEF);
        chk("C_mem44",  64'(mem[8'h11]), 64'hDEADBEEF);

        // ---------------- D: JMP and BEQ taken / not taken
        clear_mem();
        load(32'h00, enc(8'h09, 4'd0, 4'd0, 16'd3));
        load(32'h10, enc(8'h05, 4'd2, 4'd0, 16'd7));
        load(32'h14, enc(8'h08, 4'd1, 4'd2, 16'd5));
        load(32'h18, enc(8'h09, 4'd0, 4'd0, 16'd1));
        load(32'h1C, enc(8'h09, 4'd0, 4'd0, 16'd4));
        load(32'h20, enc(8'h08, 4'd1, 4'd1, 16'hFFFE));
        load(32'h30, enc(8'hFF, 4'd0, 4'd0, 16'd0));
        do_reset();
        repeat (3) step();
        chk("D_jmp",     64'(o_MemAddr), 64'h10);
        repeat (4) step();
        chk("D_addi",    64'(o_MemAddr), 64'h14);
        repeat (3) step();
        chk("D_beq_nt",  64'(o_MemAddr), 64'h18);
        repeat (3) step();
        chk("D_jmp2",    64'(o_MemAddr), 64'h20);
        repeat (3) step();
        chk("D_beq_t",   64'(o_MemAddr), 64'h1C);
        repeat (3) step();
        chk("D_jmp3",    64'(o_MemAddr), 64'h30);
        run_until_halt(10, n);
        chk("D_halt2",   64'(n),    64'd2);
        chk("D_pc",      64'(o_Pc), 64'h34);

        // ---------------- G: branch target and PC wrap at 2^32
        clear_mem();
        load(32'h00, enc(8'h09, 4'd0, 4'd0, 16'hFFFE));
        load(32'h3FC, enc(8'h09, 4'd0, 4'd0, 16'd1));
        load(32'h04, enc(8'hFF, 4'd0, 4'd0, 16'd0));
        do_reset();
        repeat (3) step();
        chk("G_tgt_wrap", 64'(o_MemAddr), 64'hFFFFFFFC);
        repeat (3) step();
        chk("G_pc_wrap",  64'(o_MemAddr), 64'h4);
        run_until_halt(10, n);
        chk("G_halt",     64'(n),    64'd2);
        chk("G_pc",       64'(o_Pc), 64'h8);

        // ---------------- E: illegal opcode trap
        clear_mem();
        load(32'h00, enc(8'h42, 4'd1, 4'd0, 16'd5));
        do_reset();
        w0 = wr_cnt;
        step();
        chk("E_c1_halted", 64'(o_Halted), 64'd0);
        chk("E_c1_req",    64'(o_MemReq), 64'd0);
        step();
        chk("E_halted",  64'(o_Halted),  64'd1);
        chk("E_illegal", 64'(o_Illegal), 64'd1);
        chk("E_pc",      64'(o_Pc),      64'h4);
        repeat (5) step();
        chk("E_req_off", 64'(o_MemReq),    64'd0);
        chk("E_frozen",  64'(o_Pc),        64'h4);
        chk("E_no_wr",   64'(wr_cnt - w0), 64'd0);

        // ---------------- F: reset in the middle of a pending SW
        clear_mem();
        load(32'h00, enc(8'h05, 4'd1, 4'd0, 16'h1234));
        load(32'h04, enc(8'h07, 4'd1, 4'd0, 16'h60));
        load(32'h08, enc(8'h05, 4'd0, 4'd0, 16'd9));
        load(32'h0C, enc(8'h07, 4'd0, 4'd0, 16'h64));
        load(32'h10, enc(8'hFF, 4'd0, 4'd0, 16'd0));
        load(32'h60, 32'hAAAAAAAA);
        load(32'h64, 32'h55555555);
        do_reset();
        chk("F_ill_clr",  64'(o_Illegal), 64'd0);
        chk("F_halt_clr", 64'(o_Halted),  64'd0);
        w0 = wr_cnt;
        repeat (6) step();
        rdy = 1'b0;
        step();
        chk("F_sw_pend", 64'(port()), {30'd0, 1'b1, 1'b1, 32'h60});
        step();
        i_Rst = 1'b1;
        rdy   = 1'b1;
        #1;
        chk("F_rst_req0", 64'(o_MemReq), 64'd0);
        step();
        i_Rst = 1'b0;
        #1;
        chk("F_pc",      64'(o_Pc),        64'h0);
        chk("F_refetch", 64'(port()),      {30'd0, 1'b1, 1'b0, 32'h0});
        chk("F_no_wr",   64'(wr_cnt - w0), 64'd0);
        chk("F_mem60",   64'(mem[8'h18]),  64'hAAAAAAAA);
        run_until_halt(100, n);
        chk("F_cycles",  64'(n),           64'd18);
        chk("F_sw_done", 64'(mem[8'h18]),  64'h00001234);
        chk("F_r0",      64'(mem[8'h19]),  64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pqp_multiciclo.md
Name: pqp_multiciclo

Overview:
- Parametrised multi-cycle successor to the single-cycle PQP core.
- Same 32-bit instruction format and 8-bit opcode space, extended with BEQ and an illegal-opcode trap.
- A single shared memory port with a ready handshake replaces the ideal dual-port memory, so wait states are tolerated.
- Sits between the top-level testbench/SoC and one external unified instruction/data memory.

Parameters:
- DATA_W, 32, datapath/register width. Must be >= 32; the instruction is taken from i_MemRData[31:0].
- ADDR_W, 32, byte-address width of PC and o_MemAddr. Addresses wrap modulo 2^ADDR_W.
- NUM_REGS, 16, register count, 2..16. Register indices >= NUM_REGS read 0 and ignore writes.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst  in  1  synchronous active-high reset.
- o_MemReq  out  1  memory request; held high until accepted.
- o_MemWe  out  1  1 = write, 0 = read; valid while o_MemReq is high.
- o_MemAddr  out  ADDR_W  byte address; stable while o_MemReq is high.
- o_MemWData  out  DATA_W  store data; valid when o_MemWe is high.
- i_MemRData  in  DATA_W  read data; valid in the cycle i_MemReady is high.
- i_MemReady  in  1  request accepted/completed at this edge.
- o_Pc  out  ADDR_W  current PC.
- o_Halted  out  1  core is in the HALT state.
- o_Illegal  out  1  sticky: halted because of an undefined opcode.

Behaviour:
- Instruction format:
  - opcode = [31:24]
  - ra = [23:20] (destination and source 1)
  - rb = [19:16] (source 2)
  - imm = [15:0], sign-extended to DATA_W
- r0 reads as zero; writes to r0 are discarded.
- Opcodes:
  - 0x00 NOP
  - 0x01 ADD: ra = ra + rb
  - 0x02 SUB: ra = ra - rb
  - 0x03 AND
  - 0x04 OR
  - 0x05 ADDI: ra = ra + sext(imm)
  - 0x06 LW: ra = mem[rb + sext(imm)]
  - 0x07 SW: mem[rb + sext(imm)] = ra
  - 0x08 BEQ: if ra == rb, PC = PC+4 + (sext(imm) << 2)
  - 0x09 JMP: PC = PC+4 + (sext(imm) << 2)
  - 0xFF HALT
  - any other value: illegal.
- Arithmetic is modulo 2^DATA_W with no flags. Memory addresses use the low ADDR_W bits of the sum.
- FSM states and transitions:
  - FETCH: o_MemReq=1, o_MemWe=0, o_MemAddr=PC. Stay until i_MemReady=1. On the accepting edge, IR <= i_MemRData[31:0], PC <= PC+4, go to DECODE.
  - DECODE: latch A=R[ra], B=R[rb].
    - HALT -> HALT.
    - Illegal -> HALT with o_Illegal <= 1.
    - Otherwise -> EXEC.
  - EXEC: compute ALU result, address or branch target.
    - ALU/ADDI -> WB.
    - LW/SW -> MEM.
    - BEQ taken / JMP: PC <= target, then -> FETCH.
    - BEQ not taken / NOP -> FETCH.
  - MEM: o_MemReq=1, o_MemAddr=addr, o_MemWe=(SW), o_MemWData=A. Stay until i_MemReady=1.
    - LW: latch MDR, -> WB.
    - SW: -> FETCH.
  - WB: R[ra] <= ALU result or MDR, then -> FETCH.
  - HALT: absorbing until reset. o_MemReq=0, o_Halted=1, PC frozen.
- Cycle counts with zero wait states (i_MemReady tied high):
  - NOP, BEQ, JMP = 3 cycles
  - ALU, ADDI, SW = 4 cycles
  - LW = 5 cycles
  - HALT reaches the HALT state 2 cycles after its fetch begins.
- Each wait cycle adds 1.
- o_MemReq is driven from the state only, never combinationally from i_MemReady. Addr, We and WData must not change while a request is pending.
- Reset: at any edge with i_Rst=1, regardless of state (including mid-request):
  - state <= FETCH, PC <= RESET_PC
  - all registers <= 0
  - o_Illegal <= 0, o_Halted = 0
  - o_MemReq is forced 0 during the reset cycle.
  - The first fetch request is issued in the first cycle after i_Rst falls.
- PC wraps from 2^ADDR_W-4 to 0. Branch targets wrap the same way.
- i_MemReady while o_MemReq=0 is ignored.

Test Plan:
- Reset then i_MemReady=1. Program: ADDI r1,5; ADDI r2,7; ADD r1,r2; HALT at 0x0, 0x4, 0x8, 0xC -> r1=12, o_Halted=1 at cycle 14, o_Pc=0x10, o_Illegal=0.
- SW r1,0x40(r0) then LW r3,0x40(r0), with r1=0xDEADBEEF -> a write request with addr 0x40 and WData 0xDEADBEEF, then r3=0xDEADBEEF. LW takes 5 cycles.
- BEQ r1,r1,imm=-2 at 0x20 -> next fetch address 0x1C. BEQ with r1≠r2 -> next fetch 0x24. JMP imm=3 at 0x0 -> fetch 0x10.
- i_MemReady held low 3 cycles during a FETCH and during an LW MEM -> request signals stable throughout, and each instruction is exactly 3 cycles longer.
- Opcode 0x42 -> o_Illegal=1 and o_Halted=1 two cycles after fetch; no register or memory write; o_MemReq stays 0.
- Assert i_Rst for 1 cycle mid-MEM of an SW -> no write completes after the reset edge, PC=RESET_PC, and a fetch request is issued on the next cycle. ADDI r0,9 -> r0 still reads 0.
